alu_pipe: RTL and testbench

Parametrised, pipelined successor to the single-cycle ALU: a two-stage registered ALU with valid/ready handshakes on input and output, a configurable data width, an extended opcode set (shifts, rotates, increment/decrement) and an internal accumulator. It sits between a stimulus/issue master and any consumer that can apply backpressure, and sustains one operation per cycle when unstalled.

---
 rtl/alu_pipe.sv | 201 ++++++++++++++++++++
 tb/tb_alu_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes and an internal accumulator.
// Stage 1 registers the request; stage 2 computes and registers the result.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int OPW   = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [OPW-1:0]   opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam logic [OPW-1:0] OP_ADD     = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB     = OPW'(1);
  localparam logic [OPW-1:0] OP_AND     = OPW'(2);
  localparam logic [OPW-1:0] OP_OR      = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR     = OPW'(4);
  localparam logic [OPW-1:0] OP_NOT     = OPW'(5);
  localparam logic [OPW-1:0] OP_SHL     = OPW'(6);
  localparam logic [OPW-1:0] OP_SHR     = OPW'(7);
  localparam logic [OPW-1:0] OP_SAR     = OPW'(8);
  localparam logic [OPW-1:0] OP_ROL     = OPW'(9);
  localparam logic [OPW-1:0] OP_INC     = OPW'(10);
  localparam logic [OPW-1:0] OP_DEC     = OPW'(11);
  localparam logic [OPW-1:0] OP_ACC_ADD = OPW'(12);
  localparam logic [OPW-1:0] OP_ACC_CLR = OPW'(13);

  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [SHW:0]     WIDTH_SH  = (SHW+1)'(WIDTH);

  logic             advance;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [OPW-1:0]   s1_op;

  logic [WIDTH-1:0] acc;

  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] arith_x;
  logic [WIDTH-1:0] arith_y;
  logic             arith_sub;
  logic [WIDTH:0]   arith_res;
  logic             arith_ovf;

  logic [WIDTH:0]   shl_ext;
  logic [WIDTH:0]   shr_ext;
  logic [WIDTH:0]   sar_ext;
  logic [SHW:0]     rol_rsh;
  logic [WIDTH-1:0] rol_y;

  logic [WIDTH-1:0] res_y;
  logic             res_c;
  logic             res_o;
  logic             res_ill;

  // Both stages move together; a stalled output freezes the whole pipe.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign sh = s1_b[SHW-1:0];

  always_comb begin
    arith_x   = s1_a;
    arith_y   = s1_b;
    arith_sub = 1'b0;
    case (s1_op)
      OP_SUB:     arith_sub = 1'b1;
      OP_INC:     arith_y   = ONE;
      OP_DEC: begin
        arith_y   = ONE;
        arith_sub = 1'b1;
      end
      OP_ACC_ADD: begin
        arith_x = acc;
        arith_y = s1_a;
      end
      default: ;
    endcase
  end

  // One shared WIDTH+1 bit adder; bit WIDTH is carry for add and borrow for subtract.
  always_comb begin
    if (arith_sub) begin
      arith_res = {1'b0, arith_x} - {1'b0, arith_y};
      arith_ovf = (arith_x[WIDTH-1] != arith_y[WIDTH-1]) &&
                  (arith_res[WIDTH-1] != arith_x[WIDTH-1]);
    end else begin
      arith_res = {1'b0, arith_x} + {1'b0, arith_y};
      arith_ovf = (arith_x[WIDTH-1] == arith_y[WIDTH-1]) &&
                  (arith_res[WIDTH-1] != arith_x[WIDTH-1]);
    end
  end

  // Extended shifters keep the last bit shifted out in the spare bit position.
  always_comb begin
    shl_ext = {1'b0, s1_a} << sh;
    shr_ext = {s1_a, 1'b0} >> sh;
    sar_ext = $signed({s1_a, 1'b0}) >>> sh;
    rol_rsh = WIDTH_SH - {1'b0, sh};
    rol_y   = (s1_a << sh) | (s1_a >> rol_rsh);
  end

  always_comb begin
    res_y   = '0;
    res_c   = 1'b0;
    res_o   = 1'b0;
    res_ill = 1'b0;
    case (s1_op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_ACC_ADD: begin
        res_y = arith_res[WIDTH-1:0];
        res_c = arith_res[WIDTH];
        res_o = arith_ovf;
      end
      OP_AND: res_y = s1_a & s1_b;
      OP_OR:  res_y = s1_a | s1_b;
      OP_XOR: res_y = s1_a ^ s1_b;
      OP_NOT: res_y = ~s1_a;
      OP_SHL: begin
        res_y = shl_ext[WIDTH-1:0];
        res_c = shl_ext[WIDTH];
      end
      OP_SHR: begin
        res_y = shr_ext[WIDTH:1];
        res_c = shr_ext[0];
      end
      OP_SAR: begin
        res_y = sar_ext[WIDTH:1];
        res_c = sar_ext[0];
      end
      OP_ROL: begin
        res_y = rol_y;
        res_c = (sh != '0) ? rol_y[0] : 1'b0;
      end
      OP_ACC_CLR: res_y = '0;
      default:    res_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a  <= operand_a;
        s1_b  <= operand_b;
        s1_op <= opcode;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      y         <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        y        <= res_y;
        carry    <= res_c;
        zero     <= (res_y == '0);
        overflow <= res_o;
        illegal  <= res_ill;
      end
    end
  end

  // Accumulator is written on the same edge stage 2 loads, so back-to-back ACC_ADDs chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (advance && s1_valid) begin
      if (s1_op == OP_ACC_ADD) begin
        acc <= arith_res[WIDTH-1:0];
      end else if (s1_op == OP_ACC_CLR) begin
        acc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=8): a scoreboard queue filled on
// accept is compared against every completed output beat.
module tb_alu_pipe;

  localparam int WIDTH = 8;
  localparam int OPW   = 4;

  localparam logic [3:0] OP_ADD     = 4'd0;
  localparam logic [3:0] OP_SUB     = 4'd1;
  localparam logic [3:0] OP_AND     = 4'd2;
  localparam logic [3:0] OP_OR      = 4'd3;
  localparam logic [3:0] OP_XOR     = 4'd4;
  localparam logic [3:0] OP_NOT     = 4'd5;
  localparam logic [3:0] OP_SHL     = 4'd6;
  localparam logic [3:0] OP_SHR     = 4'd7;
  localparam logic [3:0] OP_SAR     = 4'd8;
  localparam logic [3:0] OP_ROL     = 4'd9;
  localparam logic [3:0] OP_INC     = 4'd10;
  localparam logic [3:0] OP_DEC     = 4'd11;
  localparam logic [3:0] OP_ACC_ADD = 4'd12;
  localparam logic [3:0] OP_ACC_CLR = 4'd13;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [OPW-1:0]   opcode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             carry;
  logic             zero;
  logic             overflow;
  logic             illegal;

  typedef struct packed {
    logic [7:0] y;
    logic       c;
    logic       z;
    logic       o;
    logic       ill;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   beats  = 0;
  int   beats_before;

  alu_pipe #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .carry     (carry),
    .zero      (zero),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a falling edge; holds the request until accepted, then returns
  // at the next falling edge with in_valid still asserted.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                               input logic [7:0] ey, input logic ec, input logic ez,
                               input logic eo, input logic eil);
    int n;
    exp_t e;
    operand_a = a;
    operand_b = b;
    opcode    = op;
    in_valid  = 1'b1;
    n = 0;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
    end else begin
      e.y = ey; e.c = ec; e.z = ez; e.o = eo; e.ill = eil;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    checkOutput("drain_empty", exp_q.size(), 32'd0);
    @(negedge clk);
  endtask

  // Output monitor: inputs only change on falling edges, so this sample reflects the handshake.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_beat", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput($sformatf("beat%0d_y", beats), y, e.y);
        checkOutput($sformatf("beat%0d_carry", beats), carry, e.c);
        checkOutput($sformatf("beat%0d_zero", beats), zero, e.z);
        checkOutput($sformatf("beat%0d_ovf", beats), overflow, e.o);
        checkOutput($sformatf("beat%0d_illegal", beats), illegal, e.ill);
      end
      beats++;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    operand_a = '0;
    operand_b = '0;
    opcode    = '0;
    out_ready = 1'b1;
    #1;
    checkOutput("rst_out_valid", out_valid, 32'd0);
    checkOutput("rst_in_ready", in_ready, 32'd1);
    checkOutput("rst_y", y, 32'd0);
    checkOutput("rst_carry", carry, 32'd0);
    checkOutput("rst_zero", zero, 32'd0);
    checkOutput("rst_ovf", overflow, 32'd0);
    checkOutput("rst_illegal", illegal, 32'd0);
    checkOutput("rst_acc", dut.acc, 32'd0);

    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("[TB] latency and arithmetic");
    applyStimulus(8'hFF, 8'h01, OP_ADD, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1;
    checkOutput("lat_stage1_out_valid", out_valid, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("lat_stage2_out_valid", out_valid, 32'd1);
    @(negedge clk);

    applyStimulus(8'h7F, 8'h01, OP_ADD, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h00, 8'h01, OP_SUB, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h80, 8'h01, OP_SUB, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h00, 8'h00, OP_DEC, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h81, 8'h01, OP_SHL, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h80, 8'h03, OP_SAR, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h81, 8'h01, OP_ROL, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h5A, 8'h08, OP_SHR, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] accumulator and illegal opcode");
    applyStimulus(8'h00, 8'h00, OP_ACC_CLR, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h10, 8'h00, OP_ACC_ADD, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h20, 8'h00, OP_ACC_ADD, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hE0, 8'h00, OP_ACC_ADD, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h55, 8'h33, 4'd14, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(8'h00, 8'h00, OP_ACC_ADD, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    drain();
    checkOutput("acc_after_illegal", dut.acc, 32'h10);

    $display("[TB] backpressure stream");
    beats_before = beats;
    fork
      begin
        applyStimulus(8'hA5, 8'h0F, OP_XOR, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hF0, 8'h3C, OP_AND, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h0F, 8'h30, OP_OR,  8'h3F, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h55, 8'h00, OP_NOT, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hFF, 8'h00, OP_INC, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h81, 8'h01, OP_SHR, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          #1;
          checkOutput($sformatf("stall%0d_in_ready", i), in_ready, 32'd0);
          checkOutput($sformatf("stall%0d_out_valid", i), out_valid, 32'd1);
          checkOutput($sformatf("stall%0d_y", i), y, 32'h30);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    checkOutput("stream_beat_count", beats - beats_before, 32'd6);

    $display("[TB] reset with requests in flight");
    applyStimulus(8'h01, 8'h00, OP_ACC_ADD, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h02, 8'h00, OP_ACC_ADD, 8'h13, 1'b0, 1'b0, 1'b0, 1'b0);
    rst      = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("midrst_out_valid", out_valid, 32'd0);
    checkOutput("midrst_acc", dut.acc, 32'd0);
    checkOutput("midrst_y", y, 32'd0);
    checkOutput("midrst_in_ready", in_ready, 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      checkOutput($sformatf("no_stale%0d", i), out_valid, 32'd0);
    end
    @(negedge clk);
    beats_before = beats;
    applyStimulus(8'h05, 8'h00, OP_ACC_ADD, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #1;
    checkOutput("postrst_stage1_out_valid", out_valid, 32'd0);
    @(negedge clk);
    #1;
    checkOutput("postrst_stage2_out_valid", out_valid, 32'd1);
    @(negedge clk);
    drain();
    checkOutput("postrst_beat_count", beats - beats_before, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
